// File: rtl/playbus_ram_responder.sv
// PlayBus level-1 RAM target: 2**ADDR_W x DATA_W register file behind a four-phase
// sel/ready handshake with WAIT_STATES wait cycles. Define PLAYBUS_ERR_EN to add the err port.
module playbus_ram_responder #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
`ifdef PLAYBUS_ERR_EN
    output logic              err,
`endif
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_t;

    state_t            state, state_nxt;
    op_t               op_q, op_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              latch;
    logic              req_rd, req_wr;
    logic              commit;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_rd = sel & rd & ~wr;
    assign req_wr = sel & wr & ~rd;
`ifdef PLAYBUS_ERR_EN
    logic req_cf;
    assign req_cf = sel & rd & wr;
`endif

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (req_rd || req_wr) begin
                    latch     = 1'b1;
                    op_nxt    = req_wr ? OP_WR : OP_RD;
                    state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
                end
`ifdef PLAYBUS_ERR_EN
                else if (req_cf) begin
                    latch     = 1'b1;
                    op_nxt    = OP_ERR;
                    state_nxt = ACK;
                end
`endif
            end
            WAIT: begin
                if (!sel)
                    state_nxt = IDLE;
                else if (cnt == WS_LAST)
                    state_nxt = ACK;
            end
            ACK:  state_nxt = HOLD;
            HOLD: begin
                if (!sel)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write lands on the edge that enters ACK; with no wait states that is the
    // latching edge itself, so the live bus values are used instead of the latched ones.
    assign commit_addr = (state == IDLE) ? addr    : addr_q;
    assign commit_data = (state == IDLE) ? data_in : data_q;
    assign commit      = (state_nxt == ACK) && (state != ACK) && (op_nxt == OP_WR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_RD;
            cnt    <= 4'd0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            if (latch) begin
                addr_q <= addr;
                data_q <= data_in;
            end
            if (state == WAIT && state_nxt == WAIT)
                cnt <= cnt + 4'd1;
            else
                cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (commit) begin
            mem[commit_addr] <= commit_data;
        end
    end

    // Bus-facing outputs are registered: they rise on the edge leaving ACK and
    // fall on the edge where HOLD sees sel low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready    <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
        end else begin
            ready   <= (state == ACK) || (state == HOLD && sel);
            data_oe <= (state == ACK && op_q == OP_RD) || (state == HOLD && sel && data_oe);
            if (state == ACK && op_q == OP_RD)
                data_out <= mem[addr_q];
        end
    end

`ifdef PLAYBUS_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else
            err <= (state == ACK && op_q == OP_ERR) || (state == HOLD && sel && err);
    end
`endif

endmodule

// File: tb/tb_playbus_ram_responder.sv
// Directed bench for playbus_ram_responder: three instances (0, 1 and 3 wait states)
// share one bus; per-cycle outputs are captured and compared to hand-computed values.
`timescale 1ns/1ps
module tb_playbus_ram_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [3:0] data_in = 4'd0;

    logic [3:0] do0w, do1w, do3w;
    logic       oe0w, oe1w, oe3w, rdy0w, rdy1w, rdy3w;
`ifdef PLAYBUS_ERR_EN
    logic       err0w, err1w, err3w;
`endif

    always #5 clk = ~clk;

    playbus_ram_responder #(.ADDR_W(3), .DATA_W(4), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .sel(sel), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do0w), .data_oe(oe0w),
`ifdef PLAYBUS_ERR_EN
        .err(err0w),
`endif
        .ready(rdy0w));

    playbus_ram_responder #(.ADDR_W(3), .DATA_W(4), .WAIT_STATES(1)) u1 (
        .clk(clk), .reset(reset), .sel(sel), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do1w), .data_oe(oe1w),
`ifdef PLAYBUS_ERR_EN
        .err(err1w),
`endif
        .ready(rdy1w));

    playbus_ram_responder #(.ADDR_W(3), .DATA_W(4), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .sel(sel), .rd(rd), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(do3w), .data_oe(oe3w),
`ifdef PLAYBUS_ERR_EN
        .err(err3w),
`endif
        .ready(rdy3w));

    int checks = 0;
    int errors = 0;

    logic       r0 [8], r1 [8], r3 [8], oe0 [8], oe1 [8], oe3 [8], e1 [8];
    logic [3:0] d0 [8], d1 [8], d3 [8];
    logic       p_r0, p_r1, p_r3, p_oe1, p_e1;
    logic [3:0] p_d1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds a request for n edges, then drops sel for one captured edge and two idle edges.
    task automatic xact(input logic r, input logic w, input logic [2:0] a,
                        input logic [3:0] d, input int n);
        sel = 1'b1; rd = r; wr = w; addr = a; data_in = d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            r0[i] = rdy0w; r1[i] = rdy1w; r3[i] = rdy3w;
            oe0[i] = oe0w; oe1[i] = oe1w; oe3[i] = oe3w;
            d0[i] = do0w;  d1[i] = do1w;  d3[i] = do3w;
`ifdef PLAYBUS_ERR_EN
            e1[i] = err1w;
`else
            e1[i] = 1'b0;
`endif
        end
        sel = 1'b0; rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        p_r0 = rdy0w; p_r1 = rdy1w; p_r3 = rdy3w; p_oe1 = oe1w; p_d1 = do1w;
`ifdef PLAYBUS_ERR_EN
        p_e1 = err1w;
`else
        p_e1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy1w), 32'd0);
        check("rst_oe", 32'(oe1w), 32'd0);
        check("rst_data", 32'(do1w), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int a = 0; a < 8; a++) begin
            xact(1'b1, 1'b0, 3'(a), 4'h0, 6);
            check($sformatf("rd%0d_early_ready", a), 32'(r1[1]), 32'd0);
            check($sformatf("rd%0d_ready", a), 32'(r1[2]), 32'd1);
            check($sformatf("rd%0d_data", a), 32'(d1[2]), 32'd0);
            check($sformatf("rd%0d_oe", a), 32'(oe1[2]), 32'd1);
            check($sformatf("rd%0d_early_oe", a), 32'(oe1[1]), 32'd0);
            check($sformatf("rd%0d_post_oe", a), 32'(p_oe1), 32'd0);
        end

        xact(1'b0, 1'b1, 3'd2, 4'b1010, 6);
        check("wr2_ready", 32'(r1[2]), 32'd1);
        check("wr2_no_oe", 32'(oe1[3]), 32'd0);

        xact(1'b1, 1'b0, 3'd2, 4'h0, 6);
        check("rd2_data", 32'(d1[2]), 32'ha);
        check("rd2_oe", 32'(oe1[2]), 32'd1);
        check("rd2_ws0_data", 32'(d0[1]), 32'ha);
        check("rd2_ws3_data", 32'(d3[4]), 32'ha);
        check("rd2_hold_data", 32'(p_d1), 32'ha);
        check("ws0_before", 32'(r0[0]), 32'd0);
        check("ws0_rise", 32'(r0[1]), 32'd1);
        check("ws3_before", 32'(r3[3]), 32'd0);
        check("ws3_rise", 32'(r3[4]), 32'd1);
        check("ws3_hold", 32'(r3[5]), 32'd1);
        check("ws1_hold", 32'(r1[5]), 32'd1);
        check("ws0_fall", 32'(p_r0), 32'd0);
        check("ws1_fall", 32'(p_r1), 32'd0);
        check("ws3_fall", 32'(p_r3), 32'd0);

        xact(1'b1, 1'b0, 3'd3, 4'h0, 6);
        check("rd3_data", 32'(d1[2]), 32'd0);

        xact(1'b0, 1'b1, 3'd5, 4'b0110, 2);
        check("abort_ready0", 32'(r3[0]), 32'd0);
        check("abort_ready1", 32'(r3[1]), 32'd0);
        check("abort_ready_post", 32'(p_r3), 32'd0);
        check("abort_ready_idle", 32'(rdy3w), 32'd0);
        xact(1'b1, 1'b0, 3'd5, 4'h0, 6);
        check("abort_rd5_ws3", 32'(d3[4]), 32'd0);
        check("abort_rd5_ws3_oe", 32'(oe3[4]), 32'd1);
        check("abort_rd5_ws1", 32'(d1[2]), 32'h6);
        check("abort_rd5_ws0", 32'(d0[1]), 32'h6);

        xact(1'b0, 1'b0, 3'd4, 4'h0, 3);
        check("nostrobe_ws1", 32'(r1[2]), 32'd0);
        check("nostrobe_ws0", 32'(r0[2]), 32'd0);

        xact(1'b1, 1'b1, 3'd1, 4'hf, 6);
`ifdef PLAYBUS_ERR_EN
        check("cf_ready", 32'(r1[1]), 32'd1);
        check("cf_err", 32'(e1[1]), 32'd1);
        check("cf_no_oe", 32'(oe1[1]), 32'd0);
        check("cf_err_hold", 32'(e1[5]), 32'd1);
        check("cf_err_clear", 32'(p_e1), 32'd0);
`else
        check("cf_ready_early", 32'(r1[1]), 32'd0);
        check("cf_ready_late", 32'(r1[5]), 32'd0);
        check("cf_ready_ws0", 32'(r0[5]), 32'd0);
        check("cf_oe", 32'(oe1[5]), 32'd0);
`endif
        xact(1'b1, 1'b0, 3'd1, 4'h0, 6);
        check("cf_rd1_data", 32'(d1[2]), 32'd0);

        sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        check("hold_ready", 32'(rdy1w), 32'd1);
        check("hold_data", 32'(do1w), 32'ha);
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", 32'(rdy1w), 32'd0);
        check("midrst_oe", 32'(oe1w), 32'd0);
        check("midrst_data", 32'(do1w), 32'd0);
        #2 reset = 1'b0;
        sel = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        xact(1'b1, 1'b0, 3'd2, 4'h0, 6);
        check("postrst_ready", 32'(r1[2]), 32'd1);
        check("postrst_data", 32'(d1[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/playbus_ram_responder.md
Name: playbus_ram_responder

Overview:
- PlayBus level 1 target: the responder end of the bus that the PlayBus controller drives with select, read/write strobes, a 3-bit address and 4-bit data.
- Holds an 8 x 4-bit register-file RAM and answers each request with a four-phase select/ready handshake and a programmable number of wait states.
- Drives read data onto the shared data bus only while the read acknowledge is active.
- Sits beside the switch, EPROM and LED targets on the same bus.

Parameters:
- ADDR_W, 3, address width; depth = 2**ADDR_W words.
- DATA_W, 4, data word width.
- WAIT_STATES, 1, cycles spent in WAIT before acknowledge; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sel  input  1  chip select from the controller; held high for the whole transaction.
- rd  input  1  read strobe; sampled only while sel is high.
- wr  input  1  write strobe; sampled only while sel is high.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data from the bus.
- data_out  output  DATA_W  read data to the bus.
- data_oe  output  1  bus drive enable for data_out.
- ready  output  1  acknowledge to the controller.

Behaviour:
- Reset, asynchronous: FSM goes to IDLE; all RAM words = 0; data_out = 0, data_oe = 0, ready = 0; wait counter = 0.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - On sel=1 with exactly one of rd/wr high, latch addr, data_in and the operation.
  - Go to WAIT, or straight to ACK when WAIT_STATES = 0.
- WAIT:
  - Counter counts 0..WAIT_STATES-1; on the last count, go to ACK.
- ACK, exactly one cycle:
  - ready = 1.
  - Write: the RAM word at the latched address takes the latched data on the entry edge.
  - Read: data_out = RAM[latched address] and data_oe = 1.
  - Next state is HOLD.
- HOLD:
  - ready = 1 and data_oe stays as in ACK, until sel = 0; then go to IDLE with ready = 0 and data_oe = 0.
- Request latency, from the edge sampling sel to the first cycle with ready high: WAIT_STATES + 1 cycles.
- sel dropping in WAIT: abort to IDLE; no write is committed; ready never asserts.
- Strobes and address changing after latch: ignored; only the latched values are used.
- rd=1 and wr=1 together in IDLE: the conflict behaviour is set by the macro below.
- sel=1 with rd=0 and wr=0: stay in IDLE.
- Back-to-back transactions: a new request is accepted only after passing through IDLE, so sel must go low for at least one cycle.
- data_out holds its last value when data_oe = 0; it is not cleared except by reset.
- Address wrap: none is needed; every ADDR_W code is a valid word.
- Reset asserted mid-transaction: immediate return to IDLE; RAM is cleared, including any pending write.

Optional Feature:
- Macro: PLAYBUS_ERR_EN.
- Defined:
  - Adds output port err, 1 bit, reset 0.
  - A request with rd=1 and wr=1 goes directly to ACK with err = 1 and ready = 1, then HOLD.
  - No RAM access and data_oe = 0.
  - err stays high through HOLD and clears on return to IDLE.
- Not defined:
  - No err port.
  - The conflicting request is ignored; the FSM stays in IDLE until the strobes resolve to a legal request or sel drops.

Test Plan:
- Reset, then a read of every address 0..7 -> data_out = 0 each time; ready high 2 cycles after the sel sample; data_oe only while ready is high.
- Write 4'b1010 to address 2, drop sel, then read address 2 -> data_out = 4'b1010 with data_oe = 1; address 3 still reads 0.
- WAIT_STATES = 0 and WAIT_STATES = 3 builds -> ready rises 1 and 4 cycles after the sel sample; ready holds high until sel falls, then low on the next edge.
- Write 4'b0110 to address 5, drop sel in WAIT (WAIT_STATES = 3, second wait cycle) -> no ready; a read of address 5 returns 0.
- rd=wr=1 to address 1 -> with PLAYBUS_ERR_EN: err = 1 and ready = 1 after latency, RAM unchanged; without it: ready stays 0 until sel drops.
- Assert reset during the HOLD of a read of address 2 that holds 4'b1010 -> ready, data_oe and data_out go to 0 immediately; a following read of address 2 returns 0.
